// File: rtl/sram_arbiter_ctrl.sv
// Two-channel (instruction read / data read-write) arbiter driving one async SRAM bank with registered strobes.
// Latency: read fin at T+RD_WAIT+1, write fin at T+WR_WAIT+2, zero-byte write fin at T+1 (T = IDLE sample cycle).
// Backpressure: requesters hold req until their fin; the losing channel simply waits for the next IDLE cycle.
module sram_arbiter_ctrl #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 32,
  parameter int RD_WAIT       = 2,
  parameter int WR_WAIT       = 2,
  parameter int DATA_PRIORITY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_fin,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_fin,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_din,
  input  logic [DATA_W-1:0]   sram_dout,
  output logic                sram_dq_oe,
  output logic                sram_ce_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  output logic [DATA_W/8-1:0] sram_be_n
);

  localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  typedef enum logic [2:0] {IDLE, RD, WR, WR_REC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_d;   // channel owning the current access (1 = data)
  logic             last_d;  // channel granted most recently, for round-robin
  logic             pick_d;
  logic             unused_ok;

  // Byte-offset address bits are don't-care; word address uses [ADDR_W+1:2]
  assign unused_ok = ^{i_addr, d_addr};

  // Grant decision for the IDLE cycle: fixed data priority or alternate on contention
  assign pick_d = (DATA_PRIORITY != 0) ? d_req : (d_req && (!i_req || !last_d));

  // Controller FSM; every SRAM pin and fin pulse comes straight from a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt_d      <= 1'b0;
      last_d     <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_fin      <= 1'b0;
      d_fin      <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= '1;
    end else begin
      i_fin <= 1'b0;
      d_fin <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            gnt_d     <= 1'b1;
            last_d    <= 1'b1;
            sram_addr <= d_addr[ADDR_W+1:2];
            sram_din  <= d_wdata;
            if (d_we && (d_be == '0)) begin
              // Nothing to write: complete without touching the bank
              state <= DONE;
              d_fin <= 1'b1;
            end else if (d_we) begin
              state      <= WR;
              cnt        <= CNT_W'(WR_WAIT - 1);
              sram_ce_n  <= 1'b0;
              sram_we_n  <= 1'b0;
              sram_be_n  <= ~d_be;
              sram_dq_oe <= 1'b1;
            end else begin
              state     <= RD;
              cnt       <= CNT_W'(RD_WAIT - 1);
              sram_ce_n <= 1'b0;
              sram_oe_n <= 1'b0;
              sram_be_n <= '0;
            end
          end else if (i_req) begin
            gnt_d     <= 1'b0;
            last_d    <= 1'b0;
            sram_addr <= i_addr[ADDR_W+1:2];
            state     <= RD;
            cnt       <= CNT_W'(RD_WAIT - 1);
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            sram_be_n <= '0;
          end
        end
        RD: begin
          if (cnt == '0) begin
            if (gnt_d) begin
              d_rdata <= sram_dout;
              d_fin   <= 1'b1;
            end else begin
              i_rdata <= sram_dout;
              i_fin   <= 1'b1;
            end
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_be_n <= '1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR: begin
          if (cnt == '0) begin
            // Release WE first; CE and data stay driven one more cycle for hold time
            sram_we_n <= 1'b1;
            state     <= WR_REC;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_REC: begin
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_be_n  <= '1;
          d_fin      <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_be_n  <= '1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Directed bench for sram_arbiter_ctrl: default build, round-robin 16-bit build with RD_WAIT=1, 16-bit build with RD_WAIT=3.
// Completions are scoreboarded: expected channel, fin cycle and read data queued at issue, popped at each fin.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_sram_arbiter_ctrl;

  logic clk;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int          dut;
    bit          is_d;
    bit          is_rd;
    logic [31:0] rdata;
    int          at;
    bit          hold;
  } exp_t;

  exp_t q[$];

  // ---------------- DUT 0: defaults (32-bit, RD/WR wait 2, data priority)
  logic        rst0, i_req0, d_req0, d_we0;
  logic [3:0]  d_be0;
  logic [31:0] i_addr0, d_addr0, d_wdata0, i_rdata0, d_rdata0, sram_din0, sram_dout0;
  logic        i_fin0, d_fin0, sram_dq_oe0, sram_ce_n0, sram_oe_n0, sram_we_n0;
  logic [19:0] sram_addr0;
  logic [3:0]  sram_be_n0;

  // ---------------- DUT 1: 16-bit, RD_WAIT=1, round-robin
  // ---------------- DUT 2: 16-bit, RD_WAIT=3, data priority
  logic        rst12, i_req1, d_req1, d_we1, i_req2, d_req2, d_we2;
  logic [1:0]  d_be1, d_be2;
  logic [31:0] i_addr1, d_addr1, i_addr2, d_addr2;
  logic [15:0] d_wdata1, i_rdata1, d_rdata1, sram_din1, sram_dout1;
  logic [15:0] d_wdata2, i_rdata2, d_rdata2, sram_din2, sram_dout2;
  logic        i_fin1, d_fin1, sram_dq_oe1, sram_ce_n1, sram_oe_n1, sram_we_n1;
  logic        i_fin2, d_fin2, sram_dq_oe2, sram_ce_n2, sram_oe_n2, sram_we_n2;
  logic [19:0] sram_addr1, sram_addr2;
  logic [1:0]  sram_be_n1, sram_be_n2;

  // Bank contents seen by the controllers: one marker word, else an address-derived pattern
  function automatic logic [31:0] mdl32(input logic [19:0] a);
    return (a == 20'h4) ? 32'hDEADBEEF : {12'hC00, a};
  endfunction
  function automatic logic [15:0] mdl16(input logic [19:0] a);
    return {4'hB, a[11:0]};
  endfunction

  assign sram_dout0 = mdl32(sram_addr0);
  assign sram_dout1 = mdl16(sram_addr1);
  assign sram_dout2 = mdl16(sram_addr2);

  sram_arbiter_ctrl u0 (
    .clk(clk), .rst(rst0),
    .i_req(i_req0), .i_addr(i_addr0), .i_rdata(i_rdata0), .i_fin(i_fin0),
    .d_req(d_req0), .d_we(d_we0), .d_be(d_be0), .d_addr(d_addr0), .d_wdata(d_wdata0),
    .d_rdata(d_rdata0), .d_fin(d_fin0),
    .sram_addr(sram_addr0), .sram_din(sram_din0), .sram_dout(sram_dout0), .sram_dq_oe(sram_dq_oe0),
    .sram_ce_n(sram_ce_n0), .sram_oe_n(sram_oe_n0), .sram_we_n(sram_we_n0), .sram_be_n(sram_be_n0)
  );

  sram_arbiter_ctrl #(.DATA_W(16), .RD_WAIT(1), .DATA_PRIORITY(0)) u1 (
    .clk(clk), .rst(rst12),
    .i_req(i_req1), .i_addr(i_addr1), .i_rdata(i_rdata1), .i_fin(i_fin1),
    .d_req(d_req1), .d_we(d_we1), .d_be(d_be1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_rdata(d_rdata1), .d_fin(d_fin1),
    .sram_addr(sram_addr1), .sram_din(sram_din1), .sram_dout(sram_dout1), .sram_dq_oe(sram_dq_oe1),
    .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1), .sram_be_n(sram_be_n1)
  );

  sram_arbiter_ctrl #(.DATA_W(16), .RD_WAIT(3)) u2 (
    .clk(clk), .rst(rst12),
    .i_req(i_req2), .i_addr(i_addr2), .i_rdata(i_rdata2), .i_fin(i_fin2),
    .d_req(d_req2), .d_we(d_we2), .d_be(d_be2), .d_addr(d_addr2), .d_wdata(d_wdata2),
    .d_rdata(d_rdata2), .d_fin(d_fin2),
    .sram_addr(sram_addr2), .sram_din(sram_din2), .sram_dout(sram_dout2), .sram_dq_oe(sram_dq_oe2),
    .sram_ce_n(sram_ce_n2), .sram_oe_n(sram_oe_n2), .sram_we_n(sram_we_n2), .sram_be_n(sram_be_n2)
  );

  logic [2:0]  vi_fin, vd_fin;
  logic [31:0] vi_rd [3];
  logic [31:0] vd_rd [3];
  assign vi_fin = {i_fin2, i_fin1, i_fin0};
  assign vd_fin = {d_fin2, d_fin1, d_fin0};
  assign vi_rd[0] = i_rdata0;
  assign vd_rd[0] = d_rdata0;
  assign vi_rd[1] = {16'h0, i_rdata1};
  assign vd_rd[1] = {16'h0, d_rdata1};
  assign vi_rd[2] = {16'h0, i_rdata2};
  assign vd_rd[2] = {16'h0, d_rdata2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int dut, input bit is_d, input bit is_rd, input logic [31:0] rdata,
                      input int at, input bit hold);
    exp_t e;
    e.dut = dut; e.is_d = is_d; e.is_rd = is_rd; e.rdata = rdata; e.at = at; e.hold = hold;
    q.push_back(e);
  endtask

  // Wait (bounded) for the next fin on controller k, then check it against the queue head
  task automatic wait_fin(input int k, input string tag);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      seen = vi_fin[k] | vd_fin[k];
    end
    if (q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({tag, "_dut"}, k, e.dut);
      chk({tag, "_seen"}, {31'd0, seen}, 32'd1);
      chk({tag, "_chan"}, {30'd0, vi_fin[k], vd_fin[k]}, e.is_d ? 32'd1 : 32'd2);
      chk({tag, "_cycle"}, cyc, e.at);
      if (e.is_rd) chk({tag, "_rdata"}, e.is_d ? vd_rd[k] : vi_rd[k], e.rdata);
      if (!e.hold) begin
        case (k)
          0: if (e.is_d) d_req0 = 1'b0; else i_req0 = 1'b0;
          1: if (e.is_d) d_req1 = 1'b0; else i_req1 = 1'b0;
          default: if (e.is_d) d_req2 = 1'b0; else i_req2 = 1'b0;
        endcase
      end
    end
  endtask

  initial begin
    bit   any_fin;
    int   t;
    rst0 = 1'b1; rst12 = 1'b1;
    i_req0 = 1'b1; d_req0 = 1'b0; d_we0 = 1'b0; d_be0 = 4'h0;
    i_addr0 = 32'h0; d_addr0 = 32'h0; d_wdata0 = 32'h0;
    i_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0; d_be1 = 2'b0;
    i_addr1 = 32'h0; d_addr1 = 32'h0; d_wdata1 = 16'h0;
    i_req2 = 1'b0; d_req2 = 1'b0; d_we2 = 1'b0; d_be2 = 2'b0;
    i_addr2 = 32'h0; d_addr2 = 32'h0; d_wdata2 = 16'h0;

    // ---- Reset held 3 cycles with an instruction request pending
    repeat (3) @(negedge clk);
    chk("rst_strobes", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'hE);
    chk("rst_be_n", sram_be_n0, 32'hF);
    chk("rst_fin", {30'd0, i_fin0, d_fin0}, 32'd0);
    chk("rst_i_rdata", i_rdata0, 32'd0);
    chk("rst_d_rdata", d_rdata0, 32'd0);
    chk("rst_addr", sram_addr0, 32'd0);
    chk("rst_din", sram_din0, 32'd0);
    chk("rst_be_n_16", sram_be_n1, 32'h3);
    chk("rst_strobes_16", {29'd0, sram_ce_n2, sram_oe_n2, sram_we_n2}, 32'h7);
    rst0 = 1'b0; rst12 = 1'b0; i_req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_no_access", {30'd0, sram_ce_n0, i_fin0}, 32'd2);

    // ---- Instruction read, marker word at word address 4
    @(negedge clk);
    i_addr0 = 32'h0000_0010; i_req0 = 1'b1;
    push(0, 1'b0, 1'b1, 32'hDEADBEEF, cyc + 3, 1'b0);
    @(negedge clk);
    chk("ird_t1_strobes", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'h2);
    chk("ird_t1_addr", sram_addr0, 32'h4);
    chk("ird_t1_be_n", sram_be_n0, 32'h0);
    @(negedge clk);
    chk("ird_t2_strobes", {30'd0, sram_ce_n0, sram_oe_n0}, 32'd0);
    wait_fin(0, "ird");
    chk("ird_d_rdata_kept", d_rdata0, 32'd0);

    // ---- Single-byte write
    @(negedge clk);
    d_req0 = 1'b1; d_we0 = 1'b1; d_be0 = 4'b0010; d_addr0 = 32'h8; d_wdata0 = 32'h0000_AB00;
    push(0, 1'b1, 1'b0, 32'h0, cyc + 4, 1'b0);
    @(negedge clk);
    chk("bwr_t1_strobes", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'h5);
    chk("bwr_t1_be_n", sram_be_n0, 32'hD);
    chk("bwr_t1_addr", sram_addr0, 32'h2);
    chk("bwr_t1_din", sram_din0, 32'h0000_AB00);
    @(negedge clk);
    chk("bwr_t2_we", {30'd0, sram_ce_n0, sram_we_n0}, 32'd0);
    @(negedge clk);
    chk("bwr_t3_rec", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'h7);
    chk("bwr_t3_be_n", sram_be_n0, 32'hD);
    wait_fin(0, "bwr");
    chk("bwr_done_strobes", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'hE);
    chk("bwr_rdata_kept", i_rdata0, 32'hDEADBEEF);

    // ---- Write with no byte enables: fin next cycle, bank untouched
    @(negedge clk);
    d_req0 = 1'b1; d_we0 = 1'b1; d_be0 = 4'b0000;
    push(0, 1'b1, 1'b0, 32'h0, cyc + 1, 1'b0);
    wait_fin(0, "be0wr");
    chk("be0wr_strobes", {29'd0, sram_ce_n0, sram_we_n0, sram_dq_oe0}, 32'h6);

    // ---- Data read
    @(negedge clk);
    d_req0 = 1'b1; d_we0 = 1'b0; d_addr0 = 32'h20;
    push(0, 1'b1, 1'b1, 32'hC000_0008, cyc + 3, 1'b0);
    wait_fin(0, "drd");
    chk("drd_i_rdata_kept", i_rdata0, 32'hDEADBEEF);

    // ---- Simultaneous requests with data priority: data then instruction
    @(negedge clk);
    i_addr0 = 32'h40; i_req0 = 1'b1;
    d_addr0 = 32'h50; d_we0 = 1'b0; d_req0 = 1'b1;
    t = cyc;
    push(0, 1'b1, 1'b1, 32'hC000_0014, t + 3, 1'b0);
    push(0, 1'b0, 1'b1, 32'hC000_0010, t + 7, 1'b0);
    wait_fin(0, "prio_d");
    wait_fin(0, "prio_i");

    // ---- Reset during the second write cycle aborts the access
    @(negedge clk);
    d_req0 = 1'b1; d_we0 = 1'b1; d_be0 = 4'hF; d_addr0 = 32'hC; d_wdata0 = 32'h1122_3344;
    t = cyc;
    @(negedge clk);
    @(negedge clk);
    chk("abort_t2_we", {31'd0, sram_we_n0}, 32'd0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {28'd0, sram_ce_n0, sram_oe_n0, sram_we_n0, sram_dq_oe0}, 32'hE);
    chk("abort_be_n", sram_be_n0, 32'hF);
    chk("abort_rdata_clr", i_rdata0, 32'd0);
    rst0 = 1'b0; d_req0 = 1'b0;
    any_fin = d_fin0;
    repeat (4) begin
      @(negedge clk);
      any_fin = any_fin | d_fin0;
    end
    chk("abort_no_fin", {31'd0, any_fin}, 32'd0);
    @(negedge clk);
    d_req0 = 1'b1;
    push(0, 1'b1, 1'b0, 32'h0, cyc + 4, 1'b0);
    @(negedge clk);
    chk("reissue_din", sram_din0, 32'h1122_3344);
    chk("reissue_be_n", sram_be_n0, 32'h0);
    wait_fin(0, "reissue");

    // ---- Round-robin under continuous contention: D, I, D, I every 3 cycles
    @(negedge clk);
    i_addr1 = 32'h8; d_addr1 = 32'hC; d_we1 = 1'b0; i_req1 = 1'b1; d_req1 = 1'b1;
    t = cyc;
    push(1, 1'b1, 1'b1, 32'h0000_B003, t + 2, 1'b1);
    push(1, 1'b0, 1'b1, 32'h0000_B002, t + 5, 1'b1);
    push(1, 1'b1, 1'b1, 32'h0000_B003, t + 8, 1'b1);
    push(1, 1'b0, 1'b1, 32'h0000_B002, t + 11, 1'b1);
    wait_fin(1, "rr0");
    wait_fin(1, "rr1");
    wait_fin(1, "rr2");
    wait_fin(1, "rr3");
    i_req1 = 1'b0; d_req1 = 1'b0;

    // ---- RD_WAIT=1 read on the 16-bit build
    @(negedge clk);
    i_addr1 = 32'h4; i_req1 = 1'b1;
    push(1, 1'b0, 1'b1, 32'h0000_B001, cyc + 2, 1'b0);
    @(negedge clk);
    chk("rw1_t1_strobes", {30'd0, sram_ce_n1, sram_oe_n1}, 32'd0);
    chk("rw1_t1_be_n", sram_be_n1, 32'h0);
    wait_fin(1, "rw1");

    // ---- RD_WAIT=3 read and a low-byte write on the 16-bit build
    @(negedge clk);
    i_addr2 = 32'h14; i_req2 = 1'b1;
    push(2, 1'b0, 1'b1, 32'h0000_B005, cyc + 4, 1'b0);
    wait_fin(2, "rw3");
    @(negedge clk);
    d_req2 = 1'b1; d_we2 = 1'b1; d_be2 = 2'b01; d_addr2 = 32'h4; d_wdata2 = 16'h00CD;
    push(2, 1'b1, 1'b0, 32'h0, cyc + 4, 1'b0);
    @(negedge clk);
    chk("wr16_be_n", sram_be_n2, 32'h2);
    chk("wr16_din", sram_din2, 32'h0000_00CD);
    chk("wr16_we", {31'd0, sram_we_n2}, 32'd0);
    wait_fin(2, "wr16");
    chk("wr16_rdata_kept", i_rdata2, 32'h0000_B005);

    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter_ctrl.md
Name: sram_arbiter_ctrl

Overview:
- Unified external-SRAM controller. Replaces the per-half read/write helpers with one parametrised block of width DATA_W.
- Serves two requesters: an instruction read-only channel and a data read/write channel with byte enables.
- Arbitrates between the two channels and drives one asynchronous SRAM bank with registered strobes and configurable wait states.
- Sits between the CPU core's memory handshake (req/fin) and the board SRAM pins.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, data width; multiple of 8
RD_WAIT, 2, cycles CE/OE held low per read (>=1)
WR_WAIT, 2, cycles WE held low per write (>=1)
DATA_PRIORITY, 1, 1 = data channel always wins; 0 = round-robin

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
i_req  in  1  instruction read request; held until i_fin
i_addr  in  32  instruction byte address
i_rdata  out  DATA_W  instruction read data
i_fin  out  1  one-cycle completion pulse, instruction channel
d_req  in  1  data request; held until d_fin
d_we  in  1  1 = write, 0 = read
d_be  in  DATA_W/8  byte enables for writes
d_addr  in  32  data byte address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  data read data
d_fin  out  1  one-cycle completion pulse, data channel
sram_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
sram_din  out  DATA_W  data driven to SRAM
sram_dout  in  DATA_W  data returned from SRAM
sram_dq_oe  out  1  1 = tristate buffer drives sram_din
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  DATA_W/8  byte enables, active-low

Behaviour:
Reset (rst high at a clk edge):
- ce_n, oe_n, we_n = 1; be_n = all 1s; dq_oe = 0.
- sram_addr, sram_din, i_rdata, d_rdata = 0; i_fin, d_fin = 0.
- State goes to IDLE; round-robin pointer = "last granted instruction".
- Reset mid-access aborts the access the same edge: no fin, strobes deasserted. Requesters reissue.

Outputs:
- All SRAM outputs are driven from flops.
- sram_addr, sram_din and be_n are stable for the whole access.

FSM states: IDLE, RD, WR, WR_REC, DONE. A wait counter counts down in RD and WR.

IDLE:
- Sample i_req/d_req in cycle T and pick a grant:
  - DATA_PRIORITY=1: data wins.
  - DATA_PRIORITY=0: if both request, grant the channel not granted last; otherwise grant the sole requester.
- Register the granted channel's address, wdata and be.
- Go to RD (inst, or data with d_we=0) or WR (data with d_we=1).
- Data write with d_be=0: no SRAM cycle; go straight to DONE, d_fin at T+1.

RD (cycles T+1 .. T+RD_WAIT):
- ce_n=0, oe_n=0, we_n=1, be_n=0, dq_oe=0.
- On the last RD cycle, capture sram_dout into the granted channel's rdata register.
- Go to DONE.

WR (cycles T+1 .. T+WR_WAIT):
- ce_n=0, oe_n=1, we_n=0, be_n=~be, dq_oe=1.

WR_REC (cycle T+WR_WAIT+1):
- we_n=1; ce_n=0 and dq_oe=1 held for data hold time.
- Go to DONE.

DONE:
- All strobes deasserted; dq_oe=0.
- Granted channel's fin = 1 for exactly this cycle; the other channel's fin stays 0.
- Go to IDLE. req is not sampled in DONE.

Latency from request sampled in IDLE at T:
- Read: fin at T+RD_WAIT+1.
- Write: fin at T+WR_WAIT+2.
- Read back-to-back throughput: one access per RD_WAIT+2 cycles.

Handshake:
- Requester holds req, addr, data and be stable until it sees fin, then drops req at that edge.
- A req still high in the IDLE cycle after DONE is a new access.
- rdata is valid in the fin cycle and holds until that channel's next read completes. A write never alters either rdata.

Other rules:
- The non-granted channel's req is ignored, and it is not served, until the controller returns to IDLE.
- Address bits [1:0] are ignored.

Test Plan:
1. After reset: rst held 3 cycles -> all strobes high, be_n=all 1s, fins 0, rdata 0; i_req asserted while rst=1 gets no access.
2. Instruction read (RD_WAIT=2): i_addr=0x0000_0010 at T, sram_dout=0xDEADBEEF -> sram_addr=0x4, ce_n/oe_n low T+1..T+2, i_fin at T+3, i_rdata=0xDEADBEEF.
3. Byte write (WR_WAIT=2): d_we=1, d_be=4'b0010, d_addr=0x8, d_wdata=0x0000AB00 -> be_n=4'b1101 and we_n low T+1..T+2, we_n high with dq_oe=1 at T+3, d_fin at T+4; d_be=0 instead gives d_fin at T+1 with no strobe.
4. Simultaneous requests, DATA_PRIORITY=1, both held: data served first, then instruction; d_fin precedes i_fin. With DATA_PRIORITY=0 and both requesting continuously: grants alternate D, I, D, I.
5. Reset mid-access: rst asserted during the second WR cycle -> we_n, ce_n high next edge; no d_fin; a reissued write completes normally.
6. Sweep RD_WAIT ∈ {1,3} and DATA_W=16: read fin at T+2 and T+4 respectively; be_n width 2.
